// File: rtl/sun_trb_sar_pkg.sv
// Shared types and constants for the SUN_TRB SAR controller.
// Optional comparator timeout is enabled by defining SUN_TRB_SAR_TIMEOUT_EN.
package sun_trb_sar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SAMPLE  = 3'd1,
      ST_COMPARE = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_FIN     = 3'd4
   } sar_state_t;

   localparam int NBITS_MIN   = 2;
   localparam int NBITS_MAX   = 16;
   localparam int SAMPLE_MIN  = 1;
   localparam int SAMPLE_MAX  = 15;
   localparam int TIMEOUT_MIN = 2;
   localparam int TIMEOUT_MAX = 15;

   // Sample and dwell counters must hold the largest legal cycle count.
   localparam int CNT_W = 4;

   // Bit-pointer width; never narrower than one bit.
   function automatic int ptr_width(input int nbits);
      return (nbits <= 2) ? 1 : $clog2(nbits);
   endfunction

endpackage

// File: rtl/sun_trb_sar_tmo.sv
// COMPARE dwell counter: flags expiry on the last allowed COMPARE cycle.
// Only instantiated when SUN_TRB_SAR_TIMEOUT_EN is defined.
module sun_trb_sar_tmo
   import sun_trb_sar_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 7
)(
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] dwell;

   // Leaving COMPARE always passes through a non-COMPARE cycle, which rearms the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell <= '0;
      end else if (active) begin
         dwell <= dwell + CNT_W'(1);
      end else begin
         dwell <= '0;
      end
   end

   assign expire = active && (dwell == LAST);

endmodule

// File: rtl/sun_trb_sar_ctrl.sv
// Successive-approximation sequencer for the SUN_TRB SAR ADC (sample/compare/settle).
// Define SUN_TRB_SAR_TIMEOUT_EN to force a decision after TIMEOUT_CYCLES of COMPARE dwell.
module sun_trb_sar_ctrl
   import sun_trb_sar_pkg::*;
#(
   parameter int NBITS          = 9,
   parameter int SAMPLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 7
)(
   input  logic             CK,
   input  logic             RN,
   input  logic             START,
   input  logic             CMP,
   input  logic             CMP_VALID,
   output logic             SAMPLE,
   output logic             CMP_REQ,
   output logic [NBITS-1:0] SWP,
   output logic [NBITS-1:0] SWN,
   output logic [NBITS-1:0] DATA,
   output logic             DONE,
   output logic             BUSY,
   output logic             TIMEOUT_ERR
);

   localparam int                PW          = ptr_width(NBITS);
   localparam logic [PW-1:0]     PTR_TOP     = PW'(NBITS - 1);
   localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

   sar_state_t       state, state_n;
   logic [PW-1:0]    ptr, ptr_n;
   logic [CNT_W-1:0] scnt, scnt_n;
   logic [NBITS-1:0] result, result_n;
   logic [NBITS-1:0] swp_n, swn_n, data_n;
   logic             done_n, terr_n;
   logic             tmo_expire;
   logic             bit_val;

`ifdef SUN_TRB_SAR_TIMEOUT_EN
   sun_trb_sar_tmo #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (CK),
      .rst_n  (RN),
      .active (state == ST_COMPARE),
      .expire (tmo_expire)
   );
`else
   // Without the timeout COMPARE waits forever, so the error flag can never set.
   assign tmo_expire = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      scnt_n   = scnt;
      result_n = result;
      swp_n    = SWP;
      swn_n    = SWN;
      data_n   = DATA;
      done_n   = 1'b0;
      terr_n   = TIMEOUT_ERR;
      bit_val  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (START) begin
               state_n  = ST_SAMPLE;
               ptr_n    = PTR_TOP;
               scnt_n   = '0;
               result_n = '0;
               swp_n    = '0;
               swn_n    = '0;
               terr_n   = 1'b0;
            end
         end

         ST_SAMPLE: begin
            if (scnt == SAMPLE_LAST) begin
               state_n = ST_COMPARE;
            end else begin
               scnt_n = scnt + CNT_W'(1);
            end
         end

         ST_COMPARE: begin
            // A real decision always wins over a coincident timeout.
            if (CMP_VALID || tmo_expire) begin
               bit_val       = CMP_VALID & CMP;
               result_n[ptr] = bit_val;
               if (bit_val) begin
                  swn_n[ptr] = 1'b1;
               end else begin
                  swp_n[ptr] = 1'b1;
               end
               if (!CMP_VALID) begin
                  terr_n = 1'b1;
               end
               if (ptr == '0) begin
                  state_n = ST_FIN;
                  data_n  = result_n;
                  done_n  = 1'b1;
               end else begin
                  state_n = ST_SETTLE;
               end
            end
         end

         ST_SETTLE: begin
            ptr_n   = ptr - PW'(1);
            state_n = ST_COMPARE;
         end

         ST_FIN: begin
            state_n = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state       <= ST_IDLE;
         ptr         <= PTR_TOP;
         scnt        <= '0;
         result      <= '0;
         SWP         <= '0;
         SWN         <= '0;
         DATA        <= '0;
         DONE        <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         SAMPLE      <= 1'b0;
         CMP_REQ     <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         scnt        <= scnt_n;
         result      <= result_n;
         SWP         <= swp_n;
         SWN         <= swn_n;
         DATA        <= data_n;
         DONE        <= done_n;
         TIMEOUT_ERR <= terr_n;
         SAMPLE      <= (state_n == ST_SAMPLE);
         CMP_REQ     <= (state_n == ST_COMPARE);
         BUSY        <= (state_n != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_sun_trb_sar_ctrl.sv
// Scoreboard bench for sun_trb_sar_ctrl: directed conversions, abort, timeout
// (when SUN_TRB_SAR_TIMEOUT_EN is defined) and an NBITS=2 boundary instance.
module tb_sun_trb_sar_ctrl;

   localparam int NB  = 9;
   localparam int SC  = 2;
   localparam int TMO = 7;
   localparam int LAT = SC + 2*NB - 1;

   logic CK = 1'b0;
   logic RN, START, CMP, CMP_VALID;
   logic SAMPLE, CMP_REQ, DONE, BUSY, TIMEOUT_ERR;
   logic [NB-1:0] SWP, SWN, DATA;

   logic       start2;
   logic       sample2, cmp_req2, done2, busy2, terr2;
   logic [1:0] swp2, swn2, data2;

   typedef struct {
      logic [NB-1:0] data;
      logic [NB-1:0] swp;
      logic [NB-1:0] swn;
      int            done_cyc;
      logic          tmo;
   } exp_t;

   exp_t sb[$];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int done_seen  = 0;

   logic [NB-1:0] pat = 9'h165;
   int bit_idx     = NB - 1;
   int held        = 0;
   int hold_bit    = -1;
   int hold_len    = 0;
   bit never_valid = 1'b0;

   sun_trb_sar_ctrl #(
      .NBITS          (NB),
      .SAMPLE_CYCLES  (SC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CK          (CK),
      .RN          (RN),
      .START       (START),
      .CMP         (CMP),
      .CMP_VALID   (CMP_VALID),
      .SAMPLE      (SAMPLE),
      .CMP_REQ     (CMP_REQ),
      .SWP         (SWP),
      .SWN         (SWN),
      .DATA        (DATA),
      .DONE        (DONE),
      .BUSY        (BUSY),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   sun_trb_sar_ctrl #(
      .NBITS          (2),
      .SAMPLE_CYCLES  (1),
      .TIMEOUT_CYCLES (TMO)
   ) dut2 (
      .CK          (CK),
      .RN          (RN),
      .START       (start2),
      .CMP         (1'b1),
      .CMP_VALID   (1'b1),
      .SAMPLE      (sample2),
      .CMP_REQ     (cmp_req2),
      .SWP         (swp2),
      .SWN         (swn2),
      .DATA        (data2),
      .DONE        (done2),
      .BUSY        (busy2),
      .TIMEOUT_ERR (terr2)
   );

   always #5 CK = ~CK;

   always @(posedge CK) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Comparator model: walks the pattern MSB first, one bit per accepted decision.
   always @(posedge CK or negedge RN) begin
      if (!RN) begin
         bit_idx <= NB - 1;
         held    <= 0;
      end else if (CMP_REQ) begin
         if (CMP_VALID) begin
            bit_idx <= (bit_idx == 0) ? NB - 1 : bit_idx - 1;
            held    <= 0;
         end else begin
            held <= held + 1;
         end
      end
   end

   always @(negedge CK) begin
      CMP       = pat[bit_idx];
      CMP_VALID = !never_valid && !(bit_idx == hold_bit && held < hold_len);
   end

   // Monitor: every DONE pulse pops one expected conversion.
   always @(negedge CK) begin : monitor
      exp_t e;
      if (RN === 1'b1 && DONE === 1'b1) begin
         done_seen++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("data",        32'(DATA),        32'(e.data));
            checkOutput("swp",         32'(SWP),         32'(e.swp));
            checkOutput("swn",         32'(SWN),         32'(e.swn));
            checkOutput("done_cycle",  32'(cyc),         32'(e.done_cyc));
            checkOutput("timeout_err", 32'(TIMEOUT_ERR), 32'(e.tmo));
         end
      end
   end

   task automatic applyStimulus(input logic [NB-1:0] d, input int lat, input logic tmo);
      @(negedge CK);
      START = 1'b1;
      sb.push_back('{data: d, swp: ~d, swn: d, done_cyc: cyc + 1 + lat, tmo: tmo});
      @(negedge CK);
      START = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int n;
      n = 0;
      while (DONE !== 1'b1 && n < budget) begin
         @(negedge CK);
         n++;
      end
      if (DONE !== 1'b1) checkOutput("done_wait_expired", 32'd0, 32'd1);
      @(negedge CK);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s;
      int n;
      int busy_low;
      int dones;
      int seen0;

      RN     = 1'b0;
      START  = 1'b0;
      start2 = 1'b0;
      repeat (3) @(negedge CK);
      RN = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge CK);
         checkOutput("idle_outputs",
                     {SAMPLE, CMP_REQ, SWP, SWN, DATA, DONE, BUSY, TIMEOUT_ERR}, 32'd0);
      end

      $display("[TB] single conversion, pattern 0x165");
      pat = 9'h165;
      applyStimulus(9'h165, LAT, 1'b0);
      waitDone(40);

      $display("[TB] three back-to-back conversions");
      @(negedge CK);
      START = 1'b1;
      s = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         sb.push_back('{data: 9'h165, swp: 9'h09A, swn: 9'h165, done_cyc: s + 21*k + LAT, tmo: 1'b0});
      end
      busy_low = 0;
      dones    = 0;
      n        = 0;
      while (dones < 3 && n < 120) begin
         @(negedge CK);
         n++;
         if (n == 44) START = 1'b0;
         if (dones >= 1 && BUSY === 1'b0) busy_low++;
         if (DONE === 1'b1) dones++;
      end
      START = 1'b0;
      checkOutput("b2b_done_count",  32'(dones),    32'd3);
      checkOutput("b2b_idle_cycles", 32'(busy_low), 32'd2);
      @(negedge CK);

      $display("[TB] CMP_VALID withheld 3 cycles on bit 4");
      pat      = 9'h0AB;
      hold_bit = 4;
      hold_len = 3;
      applyStimulus(9'h0AB, LAT + 3, 1'b0);
      waitDone(60);
      hold_bit = -1;

      $display("[TB] reset mid-conversion");
      pat = 9'h165;
      @(negedge CK);
      START = 1'b1;
      @(negedge CK);
      START = 1'b0;
      repeat (8) @(negedge CK);
      seen0 = done_seen;
      #2 RN = 1'b0;
      #1 checkOutput("abort_outputs",
                     {SAMPLE, CMP_REQ, SWP, SWN, DATA, DONE, BUSY, TIMEOUT_ERR}, 32'd0);
      @(negedge CK);
      RN = 1'b1;
      repeat (30) @(negedge CK);
      checkOutput("abort_no_done",    32'(done_seen - seen0), 32'd0);
      checkOutput("abort_data_after", 32'(DATA),              32'd0);

`ifdef SUN_TRB_SAR_TIMEOUT_EN
      $display("[TB] comparator never valid, every bit times out");
      never_valid = 1'b1;
      applyStimulus(9'h000, SC + NB*TMO + NB - 1, 1'b1);
      waitDone(120);
      repeat (5) @(negedge CK);
      checkOutput("tmo_sticky", 32'(TIMEOUT_ERR), 32'd1);
      never_valid = 1'b0;
      pat = 9'h165;
      applyStimulus(9'h165, LAT, 1'b0);
      checkOutput("tmo_cleared", 32'(TIMEOUT_ERR), 32'd0);
      waitDone(40);
`endif

      $display("[TB] boundary NBITS=2, SAMPLE_CYCLES=1");
      @(negedge CK);
      start2 = 1'b1;
      s = cyc + 1;
      @(negedge CK);
      start2 = 1'b0;
      n = 0;
      while (done2 !== 1'b1 && n < 20) begin
         @(negedge CK);
         n++;
      end
      checkOutput("b_done",       32'(done2), 32'd1);
      checkOutput("b_done_cycle", 32'(cyc),   32'(s + 4));
      checkOutput("b_data",       32'(data2), 32'd3);
      checkOutput("b_swn",        32'(swn2),  32'd3);
      checkOutput("b_swp",        32'(swp2),  32'd0);

      repeat (3) @(negedge CK);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sun_trb_sar_ctrl.md
# sun_trb_sar_ctrl

Parametrised successive-approximation control logic for the SUN_TRB SAR ADC, replacing the hand-instanced DFRNQNX1/tristate chain with one synthesisable block. It sequences sample, compare and capacitor-switch phases for an NBITS-wide array. It drives one SWX-style switch control per bit on each side of the differential DAC, and handshakes with the latched comparator.

## Interface
Parameters:
- NBITS, 9, resolution and DAC bit count; legal 2..16
- SAMPLE_CYCLES, 2, cycles SAMPLE is held high; legal 1..15
- TIMEOUT_CYCLES, 7, maximum COMPARE dwell before a forced decision; legal 2..15; used only with SUN_TRB_SAR_TIMEOUT_EN

Ports:
- One clock; reset is asynchronous and active-low.
- CK  in  1  clock, rising-edge
- RN  in  1  asynchronous active-low reset
- START  in  1  conversion request, level-sampled in IDLE only
- CMP  in  1  comparator decision; 1 = positive side higher = bit kept
- CMP_VALID  in  1  comparator decision ready; sampled in COMPARE only
- SAMPLE  out  1  sampling switch enable
- CMP_REQ  out  1  comparator clock request
- SWP  out  NBITS  positive-array switch controls, bit k drives DAC bit k
- SWN  out  NBITS  negative-array switch controls
- DATA  out  NBITS  last completed result, held until next DONE
- DONE  out  1  one-cycle pulse when DATA updates
- BUSY  out  1  high in every state except IDLE
- TIMEOUT_ERR  out  1  sticky comparator-timeout flag

## Operation
- All outputs are registered.
- Reset values: state IDLE, all outputs 0, DATA 0, bit pointer NBITS-1.
- States: IDLE, SAMPLE, COMPARE, SETTLE, FIN.
- IDLE: START=1 -> SAMPLE. Clear SWP/SWN, clear TIMEOUT_ERR, pointer k = NBITS-1.
- SAMPLE: SAMPLE=1 for exactly SAMPLE_CYCLES cycles -> COMPARE.
- COMPARE: CMP_REQ=1. On an edge with CMP_VALID=1:
  - result[k] = CMP.
  - CMP=1 sets SWN[k]; CMP=0 sets SWP[k].
  - k>0 -> SETTLE; k=0 -> FIN.
- SETTLE: CMP_REQ=0 for one cycle (comparator precharge, DAC settling). Decrement k, -> COMPARE.
- FIN: DATA = result, DONE=1 for one cycle -> IDLE, unconditionally.
- SWP/SWN hold their final values through FIN and IDLE until the next START.
- START is ignored outside IDLE. CMP_VALID is ignored outside COMPARE.
- Asserting RN mid-conversion aborts immediately: DATA is cleared and no DONE is issued.

## Timing
- Edge 0 samples START in IDLE. With CMP_VALID tied high, FIN is entered at edge SAMPLE_CYCLES+2*NBITS-1 (default 19). DONE and the new DATA are visible in the following cycle.
- START held high gives back-to-back conversions with period SAMPLE_CYCLES+2*NBITS+1 cycles (default 21). There is exactly one IDLE cycle between conversions.
- Each extra cycle CMP_VALID stays low extends the conversion by one cycle.
- The decision for bit k updates SWP[k]/SWN[k] on the same edge that leaves COMPARE.

## Configuration
- SUN_TRB_SAR_TIMEOUT_EN defined:
  - A dwell counter runs in COMPARE.
  - If CMP_VALID is still 0 at the edge ending the TIMEOUT_CYCLES-th COMPARE cycle, the block forces decision 0 (sets SWP[k]), sets TIMEOUT_ERR, and proceeds as for a normal decision.
  - If CMP_VALID=1 on that same edge, the real decision wins and no error is raised.
  - TIMEOUT_ERR is sticky until the next START is accepted or reset.
- SUN_TRB_SAR_TIMEOUT_EN not defined: COMPARE waits indefinitely and TIMEOUT_ERR is tied 0.

## Structure
- Package sun_trb_sar_pkg holds:
  - the state enum typedef and its encoding
  - NBITS/SAMPLE_CYCLES legal-range constants
  - the pointer width function (clog2 of NBITS)
- Sub-module sun_trb_sar_tmo is the COMPARE dwell counter and timeout compare. It is instantiated only under SUN_TRB_SAR_TIMEOUT_EN.

## Test plan
- Reset then idle, START=0: all outputs 0 for 20 cycles. Assert RN mid-conversion: outputs return to 0 asynchronously and no DONE is issued.
- NBITS=9, CMP_VALID=1, CMP pattern 1,0,1,1,0,0,1,0,1: DONE appears 19 edges after the START edge, DATA=9'h165, SWN=9'h165, SWP=9'h09A.
- START held high for 3 conversions: DONE period is 21 cycles and BUSY is low exactly one cycle between conversions.
- CMP_VALID withheld 3 cycles on bit 4 only: DONE is delayed by 3 cycles and DATA is correct.
- With macro, TIMEOUT_CYCLES=7, CMP_VALID never asserted: every bit times out, DATA=0, SWP=all ones, TIMEOUT_ERR=1 until the next START.
- Boundary: NBITS=2, SAMPLE_CYCLES=1, CMP=1 always: DONE 4 edges after START, DATA=2'b11.
